ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline stage that registers decoded instructions and feeds the 64-bit ALU.
- Drives the ALU's first operand, second operand and 4-bit operation code.
- Resolves data hazards: forwards results from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts one bubble per hazard.
- Squashes its contents when a taken branch flushes the front end.

## Interface
- WIDTH, 64, datapath width
- RADDR, 5, register-address width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- id_valid_i  in  1  decode holds a valid instruction
- id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i  in  WIDTH  decode PC, sign-extended immediate, register-file read data
- id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  in  RADDR  source/destination register numbers
- id_ope_i  in  4  ALU operation code
- id_src1_pc_i, id_src2_imm_i  in  1  ALU operand 1 = PC / operand 2 = immediate
- id_reg_write_i, id_mem_read_i, id_mem_write_i, id_branch_i  in  1  control bits
- exmem_reg_write_i, memwb_reg_write_i  in  1  downstream write enables
- exmem_rd_addr_i, memwb_rd_addr_i  in  RADDR  downstream destinations
- exmem_result_i, memwb_result_i  in  WIDTH  downstream results
- flush_i  in  1  taken branch/jump resolved in EX; squash younger work
- stall_o  out  1  load-use hazard; IF/ID must hold
- ex_valid_o  out  1  EX holds a live instruction
- op1_o, op2_o  out  WIDTH  ALU operands
- ope_o  out  4  ALU operation code
- store_data_o  out  WIDTH  forwarded rs2 value, used for stores
- pc_o, imm_o  out  WIDTH  registered PC/immediate, used for branch target
- rd_addr_o  out  RADDR
- reg_write_o, mem_read_o, mem_write_o, branch_o  out  1  registered control, gated by valid

## Operation
- On each rising edge, the stage register loads one of three things (priority order):
  - Bubble if flush_i.
  - Otherwise bubble if stall_o.
  - Otherwise the decode fields, with valid = id_valid_i.
- Bubble contents: valid=0, all control bits 0, ope=0000. Data fields are don't-care but are zeroed.
- Load-use hazard: stall_o = ex_valid & mem_read_reg & rd_reg≠0 & id_valid_i & (rd_reg==id_rs1_addr_i | rd_reg==id_rs2_addr_i).
- stall_o is forced to 0 while flush_i=1.
- Forwarding is combinational on the registered rs1/rs2 data, per source:
  - EX/MEM when exmem_reg_write_i & exmem_rd_addr_i≠0 & exmem_rd_addr_i==rs_reg.
  - Otherwise MEM/WB under the same rule with memwb_* inputs.
  - Otherwise the registered register-file data.
  - EX/MEM has priority over MEM/WB when both match.
- Register x0 is never forwarded.
- Operand selection:
  - op1_o = src1_pc_reg ? pc_reg : fwd_rs1.
  - op2_o = src2_imm_reg ? imm_reg : fwd_rs2.
  - store_data_o = fwd_rs2, independent of src2_imm.
- The register file is write-first. A WB write in the same cycle as the ID read is therefore not the job of this block.
- reg_write_o, mem_read_o, mem_write_o and branch_o equal their registered bit AND ex_valid_o.

## Timing
- Latency: 1 cycle from ID inputs to the registered outputs.
- Forwarding path: zero-cycle, combinational from exmem_*/memwb_* to op1_o/op2_o/store_data_o.
- stall_o is combinational from the ID inputs and the stage register, in the same cycle. It lasts exactly 1 cycle per load-use hazard, because the bubble clears ex_valid.
- Reset: every register clears asynchronously to 0.
  - While in reset: ex_valid_o=0, ope_o=0000, all control outputs 0, stall_o=0.
  - op1_o, op2_o and store_data_o read 0, since rs_reg=0 blocks forwarding.
- Reset mid-stall or mid-flush: the stage is empty on the first edge after rst_i deasserts.
- Simultaneous flush_i and hazard: flush wins; bubble loaded; stall_o=0.

## Structure
- Shared package holds:
  - ALU opcode constants (ADD=0000, SUB=0001, SLL=0010, SLT=0011, SLTU=0100, XOR=0101, SRL=0110, SRA=0111, OR=1000, AND=1001, BGE=1011, BGEU=1100).
  - Forward-select encoding: FWD_REG=00, FWD_EXMEM=01, FWD_MEMWB=10.
- One combinational sub-module, ex_fwd_mux. It is instantiated twice (rs1, rs2) and returns the select code and the forwarded value.

## Test plan
- Reset, then id_valid_i=1, ADD, rs1_data=5, rs2_data=7, no forward match.
  → Next cycle ope_o=0000, op1_o=5, op2_o=7, ex_valid_o=1.
- EX holds rs1=3; exmem writes x3=0x10 and memwb writes x3=0x20 in the same cycle.
  → op1_o=0x10.
- Same as above with exmem_reg_write_i=0.
  → op1_o=0x20.
- Same as above with rs1=x0 and exmem_rd_addr_i=0.
  → op1_o = registered data, no forward.
- EX holds a load to x5; ID reads x5.
  → stall_o=1 for exactly one cycle.
  → Next cycle ex_valid_o=0 and all control outputs 0.
  → The following cycle the dependent instruction enters with op1_o = memwb_result_i.
- Same load-use setup with flush_i=1 in the same cycle.
  → stall_o=0; next cycle bubble.
- Assert rst_i mid-stream with valid contents.
  → All outputs 0 immediately, without waiting for a clock edge.
- src2_imm=1, imm=-4, rs2 forwarded from exmem = 9.
  → op2_o=0xFFFF_FFFF_FFFF_FFFC, store_data_o=9.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage: ALU opcodes and forward-select codes.
package ex_operand_stage_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_BGE  = 4'b1011;
    localparam logic [3:0] ALU_BGEU = 4'b1100;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-source forwarding mux: picks the youngest in-flight write to the source register.
module ex_fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int RADDR = 5
) (
    input  logic [RADDR-1:0] i_rs_addr,
    input  logic [WIDTH-1:0] i_rs_data,
    input  logic             i_exmem_reg_write,
    input  logic [RADDR-1:0] i_exmem_rd_addr,
    input  logic [WIDTH-1:0] i_exmem_result,
    input  logic             i_memwb_reg_write,
    input  logic [RADDR-1:0] i_memwb_rd_addr,
    input  logic [WIDTH-1:0] i_memwb_result,
    output logic [1:0]       o_sel,
    output logic [WIDTH-1:0] o_data
);

    fwd_sel_e w_sel;

    // x0 is hardwired to zero, so a pending write to it must never be forwarded
    always_comb begin
        w_sel = FWD_REG;
        if (i_exmem_reg_write && (i_exmem_rd_addr != '0) && (i_exmem_rd_addr == i_rs_addr))
            w_sel = FWD_EXMEM;
        else if (i_memwb_reg_write && (i_memwb_rd_addr != '0) && (i_memwb_rd_addr == i_rs_addr))
            w_sel = FWD_MEMWB;
    end

    always_comb begin
        case (w_sel)
            FWD_EXMEM: o_data = i_exmem_result;
            FWD_MEMWB: o_data = i_memwb_result;
            default:   o_data = i_rs_data;
        endcase
    end

    assign o_sel = w_sel;

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX stage register with load-use stall, branch flush and EX/MEM, MEM/WB forwarding into the ALU.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int RADDR = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [WIDTH-1:0] id_pc_i,
    input  logic [WIDTH-1:0] id_imm_i,
    input  logic [WIDTH-1:0] id_rs1_data_i,
    input  logic [WIDTH-1:0] id_rs2_data_i,
    input  logic [RADDR-1:0] id_rs1_addr_i,
    input  logic [RADDR-1:0] id_rs2_addr_i,
    input  logic [RADDR-1:0] id_rd_addr_i,
    input  logic [3:0]       id_ope_i,
    input  logic             id_src1_pc_i,
    input  logic             id_src2_imm_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             id_mem_write_i,
    input  logic             id_branch_i,
    input  logic             exmem_reg_write_i,
    input  logic             memwb_reg_write_i,
    input  logic [RADDR-1:0] exmem_rd_addr_i,
    input  logic [RADDR-1:0] memwb_rd_addr_i,
    input  logic [WIDTH-1:0] exmem_result_i,
    input  logic [WIDTH-1:0] memwb_result_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             ex_valid_o,
    output logic [WIDTH-1:0] op1_o,
    output logic [WIDTH-1:0] op2_o,
    output logic [3:0]       ope_o,
    output logic [WIDTH-1:0] store_data_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] imm_o,
    output logic [RADDR-1:0] rd_addr_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             branch_o
);

    logic             r_valid;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_imm;
    logic [WIDTH-1:0] r_rs1_data;
    logic [WIDTH-1:0] r_rs2_data;
    logic [RADDR-1:0] r_rs1_addr;
    logic [RADDR-1:0] r_rs2_addr;
    logic [RADDR-1:0] r_rd_addr;
    logic [3:0]       r_ope;
    logic             r_src1_pc;
    logic             r_src2_imm;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_branch;

    logic             w_stall;
    logic             w_bubble;
    logic [1:0]       w_rs1_sel;
    logic [1:0]       w_rs2_sel;
    logic [WIDTH-1:0] w_fwd_rs1;
    logic [WIDTH-1:0] w_fwd_rs2;
    logic             w_unused_sel;

    // A flush already kills the dependent instruction, so it overrides the hazard
    assign w_stall = !flush_i && r_valid && r_mem_read && (r_rd_addr != '0) && id_valid_i
                     && ((r_rd_addr == id_rs1_addr_i) || (r_rd_addr == id_rs2_addr_i));
    assign w_bubble = flush_i || w_stall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || w_bubble) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_ope       <= ALU_ADD;
            r_src1_pc   <= 1'b0;
            r_src2_imm  <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
        end else begin
            r_valid     <= id_valid_i;
            r_pc        <= id_pc_i;
            r_imm       <= id_imm_i;
            r_rs1_data  <= id_rs1_data_i;
            r_rs2_data  <= id_rs2_data_i;
            r_rs1_addr  <= id_rs1_addr_i;
            r_rs2_addr  <= id_rs2_addr_i;
            r_rd_addr   <= id_rd_addr_i;
            r_ope       <= id_ope_i;
            r_src1_pc   <= id_src1_pc_i;
            r_src2_imm  <= id_src2_imm_i;
            r_reg_write <= id_reg_write_i;
            r_mem_read  <= id_mem_read_i;
            r_mem_write <= id_mem_write_i;
            r_branch    <= id_branch_i;
        end
    end

    ex_fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs1 (
        .i_rs_addr         (r_rs1_addr),
        .i_rs_data         (r_rs1_data),
        .i_exmem_reg_write (exmem_reg_write_i),
        .i_exmem_rd_addr   (exmem_rd_addr_i),
        .i_exmem_result    (exmem_result_i),
        .i_memwb_reg_write (memwb_reg_write_i),
        .i_memwb_rd_addr   (memwb_rd_addr_i),
        .i_memwb_result    (memwb_result_i),
        .o_sel             (w_rs1_sel),
        .o_data            (w_fwd_rs1)
    );

    ex_fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs2 (
        .i_rs_addr         (r_rs2_addr),
        .i_rs_data         (r_rs2_data),
        .i_exmem_reg_write (exmem_reg_write_i),
        .i_exmem_rd_addr   (exmem_rd_addr_i),
        .i_exmem_result    (exmem_result_i),
        .i_memwb_reg_write (memwb_reg_write_i),
        .i_memwb_rd_addr   (memwb_rd_addr_i),
        .i_memwb_result    (memwb_result_i),
        .o_sel             (w_rs2_sel),
        .o_data            (w_fwd_rs2)
    );

    // Select codes are kept for debug visibility; the datapath uses the muxed values
    assign w_unused_sel = ^{w_rs1_sel, w_rs2_sel};

    assign stall_o      = w_stall;
    assign ex_valid_o   = r_valid;
    assign op1_o        = r_src1_pc  ? r_pc  : w_fwd_rs1;
    assign op2_o        = r_src2_imm ? r_imm : w_fwd_rs2;
    assign store_data_o = w_fwd_rs2;
    assign ope_o        = r_ope;
    assign pc_o         = r_pc;
    assign imm_o        = r_imm;
    assign rd_addr_o    = r_rd_addr;
    assign reg_write_o  = r_reg_write && r_valid;
    assign mem_read_o   = r_mem_read  && r_valid;
    assign mem_write_o  = r_mem_write && r_valid;
    assign branch_o     = r_branch    && r_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed instructions, expected outputs queued per cycle.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [63:0] id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic [3:0]  id_ope_i;
    logic        id_src1_pc_i, id_src2_imm_i;
    logic        id_reg_write_i, id_mem_read_i, id_mem_write_i, id_branch_i;
    logic        exmem_reg_write_i, memwb_reg_write_i;
    logic [4:0]  exmem_rd_addr_i, memwb_rd_addr_i;
    logic [63:0] exmem_result_i, memwb_result_i;
    logic        flush_i;
    logic        stall_o, ex_valid_o;
    logic [63:0] op1_o, op2_o, store_data_o, pc_o, imm_o;
    logic [3:0]  ope_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o, mem_read_o, mem_write_o, branch_o;

    ex_operand_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_imm_i(id_imm_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .id_ope_i(id_ope_i), .id_src1_pc_i(id_src1_pc_i), .id_src2_imm_i(id_src2_imm_i),
        .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
        .id_mem_write_i(id_mem_write_i), .id_branch_i(id_branch_i),
        .exmem_reg_write_i(exmem_reg_write_i), .memwb_reg_write_i(memwb_reg_write_i),
        .exmem_rd_addr_i(exmem_rd_addr_i), .memwb_rd_addr_i(memwb_rd_addr_i),
        .exmem_result_i(exmem_result_i), .memwb_result_i(memwb_result_i),
        .flush_i(flush_i), .stall_o(stall_o), .ex_valid_o(ex_valid_o),
        .op1_o(op1_o), .op2_o(op2_o), .ope_o(ope_o), .store_data_o(store_data_o),
        .pc_o(pc_o), .imm_o(imm_o), .rd_addr_o(rd_addr_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .branch_o(branch_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        v;
        logic        st;
        logic [3:0]  ope;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] sd;
        logic [3:0]  ctrl;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input string field, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, got, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic v, input logic st, input logic [3:0] ope,
                              input logic [63:0] op1, input logic [63:0] op2, input logic [63:0] sd,
                              input logic [3:0] ctrl);
        exp_t e;
        e.name = name; e.v = v; e.st = st; e.ope = ope;
        e.op1 = op1; e.op2 = op2; e.sd = sd; e.ctrl = ctrl;
        q.push_back(e);
    endtask

    // Monitor: outputs are compared mid-cycle, away from the rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            while (q.size() != 0) begin
                e = q.pop_front();
                chk(e.name, "ex_valid",   {63'd0, ex_valid_o}, {63'd0, e.v});
                chk(e.name, "stall",      {63'd0, stall_o},    {63'd0, e.st});
                chk(e.name, "ope",        {60'd0, ope_o},      {60'd0, e.ope});
                chk(e.name, "op1",        op1_o,               e.op1);
                chk(e.name, "op2",        op2_o,               e.op2);
                chk(e.name, "store_data", store_data_o,        e.sd);
                chk(e.name, "ctrl",       {60'd0, reg_write_o, mem_read_o, mem_write_o, branch_o},
                                          {60'd0, e.ctrl});
            end
        end
    end

    task automatic set_id(input logic v, input logic [63:0] pc, input logic [63:0] imm,
                          input logic [63:0] d1, input logic [63:0] d2,
                          input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                          input logic [3:0] ope, input logic s1pc, input logic s2imm,
                          input logic rw, input logic mr, input logic mw, input logic br);
        id_valid_i = v; id_pc_i = pc; id_imm_i = imm;
        id_rs1_data_i = d1; id_rs2_data_i = d2;
        id_rs1_addr_i = a1; id_rs2_addr_i = a2; id_rd_addr_i = rd;
        id_ope_i = ope; id_src1_pc_i = s1pc; id_src2_imm_i = s2imm;
        id_reg_write_i = rw; id_mem_read_i = mr; id_mem_write_i = mw; id_branch_i = br;
    endtask

    task automatic set_down(input logic ew, input logic [4:0] ea, input logic [63:0] er,
                            input logic ww, input logic [4:0] wa, input logic [63:0] wr);
        exmem_reg_write_i = ew; exmem_rd_addr_i = ea; exmem_result_i = er;
        memwb_reg_write_i = ww; memwb_rd_addr_i = wa; memwb_result_i = wr;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic id_idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0);
    endtask

    // Instruction shorthands used more than once
    task automatic id_instr_b();  // sub x7, x3, x6
        set_id(1, 64'h1000, 0, 64'h99, 64'h2, 5'd3, 5'd6, 5'd7, ALU_SUB, 0, 0, 1, 0, 0, 0);
    endtask
    task automatic id_load_x5();  // ld x5, 8(x1)
        set_id(1, 64'h2000, 64'd8, 64'h100, 64'h0, 5'd1, 5'd0, 5'd5, ALU_ADD, 0, 1, 1, 1, 0, 0);
    endtask
    task automatic id_use_x5();   // or x10, x5, x9
        set_id(1, 64'h2004, 0, 64'hDEAD, 64'h3, 5'd5, 5'd9, 5'd10, ALU_OR, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        set_down(0, 0, 0, 0, 0, 0);
        set_id(1, 64'h0, 0, 64'd5, 64'd7, 5'd1, 5'd2, 5'd4, ALU_ADD, 0, 0, 1, 0, 0, 0);
        #1;
        expect_out("reset", 0, 0, 4'h0, 0, 0, 0, 4'b0000);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        next_cycle();
        id_instr_b();
        expect_out("add_basic", 1, 0, ALU_ADD, 64'd5, 64'd7, 64'd7, 4'b1000);

        next_cycle();
        set_down(1, 5'd3, 64'h10, 1, 5'd3, 64'h20);
        expect_out("fwd_exmem_priority", 1, 0, ALU_SUB, 64'h10, 64'h2, 64'h2, 4'b1000);

        next_cycle();
        set_down(0, 5'd3, 64'h10, 1, 5'd3, 64'h20);
        set_id(1, 64'h1004, 0, 64'h55, 64'h2, 5'd0, 5'd6, 5'd8, ALU_XOR, 0, 0, 1, 0, 0, 0);
        expect_out("fwd_memwb", 1, 0, ALU_SUB, 64'h20, 64'h2, 64'h2, 4'b1000);

        next_cycle();
        set_down(1, 5'd0, 64'h10, 1, 5'd0, 64'h20);
        id_load_x5();
        expect_out("x0_no_fwd", 1, 0, ALU_XOR, 64'h55, 64'h2, 64'h2, 4'b1000);

        next_cycle();
        set_down(0, 0, 0, 0, 0, 0);
        id_use_x5();
        expect_out("load_use_stall", 1, 1, ALU_ADD, 64'h100, 64'd8, 64'h0, 4'b1100);

        next_cycle();
        expect_out("load_use_bubble", 0, 0, 4'h0, 0, 0, 0, 4'b0000);

        next_cycle();
        set_down(0, 0, 0, 1, 5'd5, 64'h77);
        id_load_x5();
        expect_out("load_use_fwd", 1, 0, ALU_OR, 64'h77, 64'h3, 64'h3, 4'b1000);

        next_cycle();
        set_down(0, 0, 0, 0, 0, 0);
        id_use_x5();
        flush_i = 1'b1;
        expect_out("flush_hazard", 1, 0, ALU_ADD, 64'h100, 64'd8, 64'h0, 4'b1100);

        next_cycle();
        flush_i = 1'b0;
        set_id(1, 64'h3000, 0, 64'h11, 64'h22, 5'd1, 5'd2, 5'd3, ALU_AND, 0, 0, 1, 0, 1, 0);
        expect_out("flush_bubble", 0, 0, 4'h0, 0, 0, 0, 4'b0000);

        next_cycle();
        expect_out("pre_reset", 1, 0, ALU_AND, 64'h11, 64'h22, 64'h22, 4'b1010);

        next_cycle();
        rst_i = 1'b1;
        expect_out("async_reset", 0, 0, 4'h0, 0, 0, 0, 4'b0000);

        next_cycle();
        rst_i = 1'b0;
        set_id(1, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h2, 64'h1, 5'd1, 5'd4, 5'd6, ALU_SUB, 0, 1, 1, 0, 1, 0);
        expect_out("post_reset_empty", 0, 0, 4'h0, 0, 0, 0, 4'b0000);

        next_cycle();
        set_down(1, 5'd4, 64'd9, 0, 0, 0);
        id_idle();
        expect_out("imm_and_store", 1, 0, ALU_SUB, 64'h2, 64'hFFFF_FFFF_FFFF_FFFC, 64'd9, 4'b1010);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk_i);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
